// File: rtl/video_pattern_gen.sv
// Test-pattern video source: free-running raster timing with one solid white rectangle.
// Every output reflects the counter position of the previous enabled clock.
module video_pattern_gen #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int H_FP   = 2,
    parameter int H_SYNC = 4,
    parameter int H_BP   = 2,
    parameter int V_FP   = 1,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       enable,
    input  logic [9:0] rect_x0,
    input  logic [9:0] rect_y0,
    input  logic [9:0] rect_x1,
    input  logic [9:0] rect_y1,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [9:0] c_w,
    output logic [9:0] c_h,
    output logic       frame_done,
    output logic       busy
);
    localparam int H_TOTAL = IMG_W + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = IMG_H + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] W_ACT  = 10'(IMG_W);
    localparam logic [9:0] H_ACT  = 10'(IMG_H);
    localparam logic [9:0] W_END  = 10'(IMG_W - 1);
    localparam logic [9:0] H_END  = 10'(IMG_H - 1);
    localparam logic [9:0] HS_S   = 10'(IMG_W + H_FP);
    localparam logic [9:0] HS_E   = 10'(IMG_W + H_FP + H_SYNC);
    localparam logic [9:0] VS_S   = 10'(IMG_H + V_FP);
    localparam logic [9:0] VS_E   = 10'(IMG_H + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    state_t     state_q;
    logic [9:0] hcnt_q, vcnt_q;
    logic [9:0] x0_q, y0_q, x1_q, y1_q;
    logic       de_q, hs_q, vs_q, fg_q, fd_q, busy_q;
    logic [9:0] cw_q, ch_q;

    logic       de_d, hs_d, vs_d, fg_d, fd_d, busy_d;
    logic [9:0] cw_d, ch_d;

    always_comb begin
        de_d   = 1'b0;
        hs_d   = 1'b0;
        vs_d   = 1'b0;
        fg_d   = 1'b0;
        fd_d   = 1'b0;
        cw_d   = '0;
        ch_d   = '0;
        busy_d = (state_q != IDLE);
        if (state_q == RUN) begin
            de_d = (hcnt_q < W_ACT) && (vcnt_q < H_ACT);
            hs_d = (hcnt_q >= HS_S) && (hcnt_q < HS_E);
            vs_d = (vcnt_q >= VS_S) && (vcnt_q < VS_E);
            // An inverted corner pair can never satisfy both bounds, so it draws nothing.
            fg_d = de_d && (x0_q <= hcnt_q) && (hcnt_q <= x1_q)
                        && (y0_q <= vcnt_q) && (vcnt_q <= y1_q);
            fd_d = de_d && (hcnt_q == W_END) && (vcnt_q == H_END);
            cw_d = hcnt_q;
            ch_d = vcnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            fg_q    <= 1'b0;
            fd_q    <= 1'b0;
            cw_q    <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b0;
        end else if (ce) begin
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fg_q   <= fg_d;
            fd_q   <= fd_d;
            cw_q   <= cw_d;
            ch_q   <= ch_d;
            busy_q <= busy_d;
            case (state_q)
                IDLE: begin
                    hcnt_q <= '0;
                    vcnt_q <= '0;
                    if (enable) begin
                        state_q <= RUN;
                        x0_q    <= rect_x0;
                        y0_q    <= rect_y0;
                        x1_q    <= rect_x1;
                        y1_q    <= rect_y1;
                    end
                end
                RUN: begin
                    if (hcnt_q == H_LAST) begin
                        hcnt_q <= '0;
                        if (vcnt_q == V_LAST) begin
                            vcnt_q <= '0;
                            // enable is only looked at on the frame boundary, so frames are never cut short.
                            if (enable) begin
                                x0_q <= rect_x0;
                                y0_q <= rect_y0;
                                x1_q <= rect_x1;
                                y1_q <= rect_y1;
                            end else begin
                                state_q <= LAST;
                            end
                        end else begin
                            vcnt_q <= vcnt_q + 10'd1;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 10'd1;
                    end
                end
                LAST: begin
                    state_q <= IDLE;
                    hcnt_q  <= '0;
                    vcnt_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign de         = de_q;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign red        = {8{fg_q}};
    assign green      = {8{fg_q}};
    assign blue       = {8{fg_q}};
    assign c_w        = cw_q;
    assign c_h        = ch_q;
    assign frame_done = fd_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: a raster-position model predicts every output
// cycle, a monitor compares, and per-frame pixel statistics are checked for directed rectangles.
module tb_video_pattern_gen;
    localparam int IMG_W = 64, IMG_H = 64;
    localparam int H_FP = 2, H_SYNC = 4, H_BP = 2;
    localparam int V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int H_TOTAL = IMG_W + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = IMG_H + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic       clk = 1'b0;
    logic       rst, ce, enable;
    logic [9:0] rect_x0, rect_y0, rect_x1, rect_y1;
    logic       de, hsync, vsync, frame_done, busy;
    logic [7:0] red, green, blue;
    logic [9:0] c_w, c_h;

    video_pattern_gen dut (
        .clk(clk), .rst(rst), .ce(ce), .enable(enable),
        .rect_x0(rect_x0), .rect_y0(rect_y0), .rect_x1(rect_x1), .rect_y1(rect_y1),
        .de(de), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .c_w(c_w), .c_h(c_h), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       de, hs, vs;
        logic [7:0] r, g, b;
        logic [9:0] cw, ch;
        logic       fd, busy;
    } out_t;

    typedef struct {
        int de_n, ff_n, xmin, xmax, ymin, ymax, period;
    } fstat_t;

    out_t   exp_q[$];
    out_t   prev_exp;
    fstat_t fq[$];
    int     checks = 0, failures = 0;

    // Reference model: mode 0 idle, 1 streaming, 2 trailing cycle; pos is a linear raster index.
    int mode, pos, lx0, ly0, lx1, ly1;

    function automatic out_t pix(input int p);
        out_t o;
        int h, v;
        logic fg;
        h = p % H_TOTAL;
        v = p / H_TOTAL;
        o = '0;
        o.busy = 1'b1;
        o.cw = 10'(h);
        o.ch = 10'(v);
        o.de = (h < IMG_W) && (v < IMG_H);
        o.hs = (h >= IMG_W + H_FP) && (h < IMG_W + H_FP + H_SYNC);
        o.vs = (v >= IMG_H + V_FP) && (v < IMG_H + V_FP + V_SYNC);
        fg = o.de && (lx0 <= h) && (h <= lx1) && (ly0 <= v) && (v <= ly1);
        o.r = fg ? 8'hFF : 8'h00;
        o.g = o.r;
        o.b = o.r;
        o.fd = o.de && (h == IMG_W - 1) && (v == IMG_H - 1);
        return o;
    endfunction

    task automatic latch_rect();
        lx0 = int'(rect_x0); ly0 = int'(rect_y0);
        lx1 = int'(rect_x1); ly1 = int'(rect_y1);
    endtask

    task automatic model_reset();
        mode = 0; pos = 0;
        lx0 = 0; ly0 = 0; lx1 = 0; ly1 = 0;
        prev_exp = '0;
    endtask

    task automatic model_step();
        out_t e;
        if (!rst) begin
            model_reset();
            e = '0;
        end else if (!ce) begin
            e = prev_exp;
        end else begin
            case (mode)
                0: begin
                    e = '0;
                    if (enable) begin mode = 1; pos = 0; latch_rect(); end
                end
                1: begin
                    e = pix(pos);
                    if (pos == FRAME - 1) begin
                        if (enable) begin pos = 0; latch_rect(); end
                        else mode = 2;
                    end else pos++;
                end
                default: begin
                    e = '0;
                    e.busy = 1'b1;
                    mode = 0;
                end
            endcase
        end
        prev_exp = e;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, expv);
        end
    endtask

    // Monitor: compare each cycle, and gather per-frame statistics when enabled.
    logic stat_en = 1'b0;
    int   s_de = 0, s_ff = 0, s_cyc = 0;
    int   s_xmin = 1023, s_xmax = -1, s_ymin = 1023, s_ymax = -1;

    always @(negedge clk) begin
        out_t e, g;
        fstat_t st;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g.de = de; g.hs = hsync; g.vs = vsync;
            g.r = red; g.g = green; g.b = blue;
            g.cw = c_w; g.ch = c_h; g.fd = frame_done; g.busy = busy;
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t got de=%b hs=%b vs=%b rgb=%h%h%h cw=%0d ch=%0d fd=%b busy=%b exp de=%b hs=%b vs=%b rgb=%h%h%h cw=%0d ch=%0d fd=%b busy=%b",
                         $time, g.de, g.hs, g.vs, g.r, g.g, g.b, g.cw, g.ch, g.fd, g.busy,
                         e.de, e.hs, e.vs, e.r, e.g, e.b, e.cw, e.ch, e.fd, e.busy);
            end
            if (stat_en) begin
                s_cyc++;
                if (de) s_de++;
                if (de && red == 8'hFF && green == 8'hFF && blue == 8'hFF) begin
                    s_ff++;
                    if (int'(c_w) < s_xmin) s_xmin = int'(c_w);
                    if (int'(c_w) > s_xmax) s_xmax = int'(c_w);
                    if (int'(c_h) < s_ymin) s_ymin = int'(c_h);
                    if (int'(c_h) > s_ymax) s_ymax = int'(c_h);
                end
                if (frame_done) begin
                    st.de_n = s_de; st.ff_n = s_ff; st.period = s_cyc;
                    st.xmin = s_xmin; st.xmax = s_xmax; st.ymin = s_ymin; st.ymax = s_ymax;
                    fq.push_back(st);
                    s_de = 0; s_ff = 0; s_cyc = 0;
                    s_xmin = 1023; s_xmax = -1; s_ymin = 1023; s_ymax = -1;
                end
            end
        end
    end

    task automatic set_rect(input int x0, input int y0, input int x1, input int y1);
        rect_x0 = 10'(x0); rect_y0 = 10'(y0); rect_x1 = 10'(x1); rect_y1 = 10'(y1);
    endtask

    task automatic wait_pos(input string name, input int target);
        bit hit;
        hit = 0;
        for (int n = 0; n < 3 * FRAME; n++) begin
            tick();
            if (mode == 1 && pos == target) begin hit = 1; break; end
        end
        chk(name, int'(hit), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; ce = 1'b0; enable = 1'b0;
        set_rect(0, 0, 0, 0);
        model_reset();
        repeat (3) tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_de", int'(de), 0);
        rst = 1'b1;
        tick();

        // Four back-to-back frames with directed rectangles, changed mid-frame.
        ce = 1'b1; enable = 1'b1; stat_en = 1'b1;
        set_rect(10, 20, 15, 25);
        tick();
        repeat (FRAME) tick();
        repeat (2000) tick();
        set_rect(0, 0, 63, 63);
        repeat (FRAME - 2000) tick();
        repeat (2000) tick();
        set_rect(40, 5, 30, 9);
        repeat (FRAME - 2000) tick();
        repeat (FRAME) tick();
        tick();
        stat_en = 1'b0;
        chk("frame_count", fq.size(), 4);
        if (fq.size() == 4) begin
            chk("f1_ff", fq[0].ff_n, 36);
            chk("f1_xmin", fq[0].xmin, 10);
            chk("f1_xmax", fq[0].xmax, 15);
            chk("f1_ymin", fq[0].ymin, 20);
            chk("f1_ymax", fq[0].ymax, 25);
            chk("f2_ff_old_rect", fq[1].ff_n, 36);
            chk("f3_ff_full", fq[2].ff_n, 4096);
            chk("f4_ff_empty", fq[3].ff_n, 0);
            for (int i = 0; i < 4; i++) chk($sformatf("f%0d_de", i + 1), fq[i].de_n, 4096);
            for (int i = 1; i < 4; i++) chk($sformatf("f%0d_period", i + 1), fq[i].period, FRAME);
        end

        // ce toggling every cycle, then random ce/enable/rect.
        for (int i = 0; i < 3000; i++) begin
            ce = ~ce;
            if (i % 500 == 0)
                set_rect($urandom_range(0, 70), $urandom_range(0, 70), $urandom_range(0, 70), $urandom_range(0, 70));
            tick();
        end
        for (int blk = 0; blk < 6; blk++) begin
            enable = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 1500; i++) begin
                ce = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 99) == 0)
                    set_rect($urandom_range(0, 70), $urandom_range(0, 70), $urandom_range(0, 70), $urandom_range(0, 70));
                tick();
            end
        end

        // enable dropped at pixel (5,5): frame completes, then stays idle.
        ce = 1'b1; enable = 1'b1;
        wait_pos("wait_pix_5_5", 5 * H_TOTAL + 5);
        enable = 1'b0;
        repeat (FRAME + 10) tick();
        chk("drop_busy", int'(busy), 0);
        chk("drop_de", int'(de), 0);
        chk("drop_model_idle", mode, 0);

        // Asynchronous reset while showing pixel (30,40).
        enable = 1'b1;
        wait_pos("wait_pix_30_40", 40 * H_TOTAL + 30);
        tick();
        chk("pre_rst_cw", int'(c_w), 30);
        chk("pre_rst_ch", int'(c_h), 40);
        #1 rst = 1'b0;
        #1;
        chk("rst_async_de_sync", int'({de, hsync, vsync}), 0);
        chk("rst_async_rgb", int'({red, green, blue}), 0);
        chk("rst_async_pos", int'({c_w, c_h}), 0);
        chk("rst_async_fd_busy", int'({frame_done, busy}), 0);
        exp_q.delete();
        model_reset();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        tick();
        chk("restart_de", int'(de), 1);
        chk("restart_cw", int'(c_w), 0);
        chk("restart_ch", int'(c_h), 0);
        repeat (FRAME / 2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameter IMG_W, default 64, active pixels per line.
REQ-002 Parameter IMG_H, default 64, active lines per frame.
REQ-003 Parameters H_FP / H_SYNC / H_BP, defaults 2 / 4 / 2, horizontal front porch / sync / back porch in clocks.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 1 / 2 / 1, vertical front porch / sync / back porch in lines.
REQ-005 clk  in  1  pixel clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 ce  in  1  clock enable; when 0, all state and outputs hold.
REQ-008 enable  in  1  request to stream frames.
REQ-009 rect_x0, rect_y0, rect_x1, rect_y1  in  10 each  foreground rectangle corners, inclusive.
REQ-010 de, hsync, vsync  out  1 each  active-high video timing, registered.
REQ-011 red, green, blue  out  8 each  pixel data, registered.
REQ-012 c_w, c_h  out  10 each  column/row of the pixel currently on the outputs.
REQ-013 frame_done  out  1  one-clock pulse on the last active pixel of each frame.
REQ-014 busy  out  1  high while a frame is in progress.

Function
REQ-015 H_TOTAL = IMG_W+H_FP+H_SYNC+H_BP; V_TOTAL = IMG_H+V_FP+V_SYNC+V_BP; counters hcnt and vcnt are 10 bits.
REQ-016 State machine: IDLE, RUN, LAST.
- IDLE: counters at 0; if ce=1 and enable=1, go to RUN and latch rect_* into internal registers.
- RUN: hcnt increments each ce cycle; wraps to 0 at H_TOTAL-1 and increments vcnt. At hcnt=H_TOTAL-1, vcnt=V_TOTAL-1: if enable=1, wrap both to 0, relatch rect_*, stay RUN; else go to LAST.
- LAST: one cycle, counters cleared, then IDLE.
REQ-017 rect_* are sampled only at frame start; changes mid-frame affect the next frame only.
REQ-018 de = (hcnt<IMG_W) and (vcnt<IMG_H), in RUN only.
REQ-019 hsync high for IMG_W+H_FP <= hcnt < IMG_W+H_FP+H_SYNC, every line including vertical blanking, RUN only.
REQ-020 vsync high for IMG_H+V_FP <= vcnt < IMG_H+V_FP+V_SYNC, for all hcnt in those lines, RUN only.
REQ-021 Pixel is foreground when de and x0<=hcnt<=x1 and y0<=vcnt<=y1: red=green=blue=8'hFF; otherwise 8'h00.
- x0>x1 or y0>y1 gives an empty rectangle.
- Corners at or beyond IMG_W-1/IMG_H-1 clip naturally.
REQ-022 All outputs are registered: counter value (h,v) in cycle N appears on outputs at cycle N+1, with c_w=h, c_h=v; latency 1 clk.
REQ-023 Outside RUN: de=hsync=vsync=0, rgb=0, c_w=c_h=0.
REQ-024 frame_done=1 exactly when outputs show c_w=IMG_W-1, c_h=IMG_H-1 with de=1.
REQ-025 busy=1 in RUN and LAST, 0 in IDLE.
REQ-026 enable deasserted mid-frame: the current frame completes in full; no partial frame is produced.
REQ-027 ce=0 for any duration: no counter advance and no output change; timing resumes exactly where it stopped.

Reset
REQ-028 On rst=0, asynchronously force:
- state=IDLE
- hcnt=vcnt=0, latched rect=0
- de=hsync=vsync=0, rgb=0, c_w=c_h=0, frame_done=0, busy=0
REQ-029 Reset asserted mid-frame aborts the frame immediately. After release, a new frame starts from (0,0) on the first ce cycle with enable=1.

Verification
REQ-030 Defaults (H_TOTAL=72, V_TOTAL=68), enable=1, ce=1 -> per frame: 4096 de cycles, 4896 cycles frame period, hsync 4 clocks starting at hcnt=66, vsync lines 65-66, one frame_done per frame.
REQ-031 Rect (10,20)-(15,25) -> exactly 36 pixels with rgb=FF, at c_w 10..15 and c_h 20..25. Feeding the output into bounding_box yields x_min=10, x_max=15, y_min=20, y_max=25.
REQ-032 Change rect to (0,0)-(63,63) mid-frame -> current frame keeps the old rectangle; next frame has all 4096 active pixels at FF.
REQ-033 Rect (40,5)-(30,9) -> zero FF pixels; de timing unchanged.
REQ-034 ce toggled 1/0 every cycle -> output sequence identical to the ce=1 run with each value held 2 cycles. enable dropped at pixel (5,5) -> frame finishes, then busy=0 and de stays 0.
REQ-035 rst pulsed low at (30,40) -> all outputs 0 within the same cycle. After release with enable=1 -> first de at c_w=0, c_h=0, one clk after the first RUN cycle.
